// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential DIV/REM unit.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Most-negative pattern; the top slices its upper N bits to get MIN_N for its width.
  localparam logic [63:0] MIN_N = 64'h8000_0000_0000_0000;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Divider controller: state register, iteration counter and the handshake/datapath strobes.
module seq_divider_ctrl
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_fast,
  input  logic i_ack,
  output logic o_ready,
  output logic o_busy,
  output logic o_done,
  output logic o_load,
  output logic o_fast_load,
  output logic o_step,
  output logic o_fix,
  output logic o_release
);

  localparam int L = cnt_width(N);

  state_t         r_state;
  logic [L-1:0]   r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           w_accept;

  assign o_ready     = (r_state == IDLE) & rst_n;
  assign w_accept    = o_ready & i_start;
  assign o_load      = w_accept & ~i_fast;
  assign o_fast_load = w_accept & i_fast;
  assign o_step      = (r_state == CALC);
  assign o_fix       = (r_state == FIX);
  assign o_release   = r_done & i_ack;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  // FSM with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {L{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && i_fast) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (i_start) begin
            r_state <= CALC;
            r_cnt   <= L'(N - 1);
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          if (r_cnt == {L{1'b0}}) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - L'(1);
          end
        end
        FIX: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          if (i_ack) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider (DIV/REM unit) with start/ready and done/ack handshakes.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  input  logic         ack,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam logic [N-1:0] MIN_VAL = MIN_N[63 -: N];

  logic         w_load, w_fast_load, w_step, w_fix, w_release;
  logic         w_dbz, w_ovf, w_fast;
  logic         w_dvd_neg, w_dvs_neg;
  logic [N-1:0] w_dvd_mag;
  logic [M-1:0] w_dvs_mag;
  logic [M:0]   w_shift;
  logic         w_geq;
  logic [M-1:0] w_rem_nxt;

  logic [N-1:0] r_quot;
  logic [M-1:0] r_dvs;
  logic [M-1:0] r_pr;
  logic         r_q_neg, r_r_neg;
  logic [N-1:0] r_q_out;
  logic [M-1:0] r_r_out;
  logic         r_dbz, r_ovf;

  seq_divider_ctrl #(.N(N)) u_ctrl (
    .clk         (clk),
    .rst_n       (reset),
    .i_start     (start),
    .i_fast      (w_fast),
    .i_ack       (ack),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_load      (w_load),
    .o_fast_load (w_fast_load),
    .o_step      (w_step),
    .o_fix       (w_fix),
    .o_release   (w_release)
  );

  assign w_dbz     = (divisor == {M{1'b0}});
  assign w_ovf     = signed_mode & (dividend == MIN_VAL) & (divisor == {M{1'b1}});
  assign w_fast    = w_dbz | w_ovf;
  assign w_dvd_neg = signed_mode & dividend[N-1];
  assign w_dvs_neg = signed_mode & divisor[M-1];
  // MIN magnitudes (e.g. -8 on M=4) still fit as unsigned after negation
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

  assign w_shift   = {r_pr, r_quot[N-1]};
  assign w_geq     = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_geq ? M'(w_shift - {1'b0, r_dvs}) : w_shift[M-1:0];

  // Operand capture, restoring iteration, sign fix and result/flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quot  <= {N{1'b0}};
      r_dvs   <= {M{1'b0}};
      r_pr    <= {M{1'b0}};
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_q_out <= {N{1'b0}};
      r_r_out <= {M{1'b0}};
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_quot  <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_pr    <= {M{1'b0}};
      r_q_neg <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg <= w_dvd_neg;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_fast_load) begin
      r_q_out <= w_dbz ? {N{1'b1}} : MIN_VAL;
      r_r_out <= w_dbz ? dividend[M-1:0] : {M{1'b0}};
      r_dbz   <= w_dbz;
      r_ovf   <= ~w_dbz;
    end else if (w_step) begin
      r_pr    <= w_rem_nxt;
      r_quot  <= {r_quot[N-2:0], w_geq};
    end else if (w_fix) begin
      r_q_out <= r_q_neg ? -r_quot : r_quot;
      r_r_out <= r_r_neg ? -r_pr : r_pr;
    end else if (w_release) begin
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
